fetch_queue: RTL and testbench

Dual-issue instruction fetch queue that sits directly upstream of the relayer unit. Each cycle it requests an aligned pair of 16-bit instructions from instruction memory and buffers them in a circular queue. It presents the two oldest instructions to the relayer, which reports back how many it consumed (0, 1 or 2). A redirect flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue instruction fetch queue feeding the relayer.
// Each cycle it requests an aligned pair of 16-bit instructions, buffers them
// in a circular queue, and presents the two oldest entries. The relayer
// reports how many it took (0..2). A redirect flushes the queue and restarts
// fetch at a new PC.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   fetch_pc / fetch_req       address of next pair / request when >= 2 slots free
//   imem_valid, imem_instr1/2  memory response for fetch_pc and fetch_pc+1
//   redirect, redirect_pc      flush and restart fetch at redirect_pc
//   instr1_out, instr2_out     two oldest entries, zero when not valid
//   out_count                  number of valid outputs, min(count, 2)
//   consume                    entries taken by the relayer (3 treated as 2)
//   count                      current occupancy
module fetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] fetch_pc,
    output logic          fetch_req,
    input  logic          imem_valid,
    input  logic [15:0]   imem_instr1,
    input  logic [15:0]   imem_instr2,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [15:0]   instr1_out,
    output logic [15:0]   instr2_out,
    output logic [1:0]    out_count,
    input  logic [1:0]    consume,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    // Highest occupancy that still leaves room for a full pair.
    localparam logic [CW-1:0] REQ_MAX = CW'(DEPTH - 2);

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] pc_q, pc_d;

    logic          push;
    logic [1:0]    consume_clamped;
    logic [1:0]    pop;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;

    // Output decode, masked by occupancy so stale storage never leaks out.
    always_comb begin
        head_p1    = head_q + PW'(1);
        fetch_req  = (count_q <= REQ_MAX);
        out_count  = (count_q >= CW'(2)) ? 2'd2 : 2'(count_q);
        instr1_out = (count_q >= CW'(1)) ? mem_q[head_q]  : 16'h0000;
        instr2_out = (count_q >= CW'(2)) ? mem_q[head_p1] : 16'h0000;
        fetch_pc   = pc_q;
        count      = count_q;
    end

    // Push/pop decisions and next-state pointers.
    always_comb begin
        tail_p1         = tail_q + PW'(1);
        push            = fetch_req && imem_valid && !redirect;
        consume_clamped = (consume == 2'd3) ? 2'd2 : consume;
        // Over-consume pops only what is actually presented.
        pop             = (consume_clamped > out_count) ? out_count : consume_clamped;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;

        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = redirect_pc;
        end else begin
            head_d  = head_q + PW'(pop);
            count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop);
            if (push) begin
                tail_d = tail_q + PW'(2);
                pc_d   = pc_q + AW'(2);
            end
        end
    end

    // Control state; reset takes priority over redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

    // Queue storage; no reset needed because outputs are masked by count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[tail_q]  <= imem_instr1;
            mem_q[tail_p1] <= imem_instr2;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a combinational instruction memory
// whose word at address a is {8'hC5, a}.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [7:0]  fetch_pc;
    logic        fetch_req;
    logic        imem_valid;
    logic [15:0] imem_instr1;
    logic [15:0] imem_instr2;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [15:0] instr1_out;
    logic [15:0] instr2_out;
    logic [1:0]  out_count;
    logic [1:0]  consume;
    logic [3:0]  count;

    int tests_run;
    int tests_failed;

    fetch_queue #(.DEPTH(8), .AW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_pc    (fetch_pc),
        .fetch_req   (fetch_req),
        .imem_valid  (imem_valid),
        .imem_instr1 (imem_instr1),
        .imem_instr2 (imem_instr2),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr1_out  (instr1_out),
        .instr2_out  (instr2_out),
        .out_count   (out_count),
        .consume     (consume),
        .count       (count)
    );

    function automatic logic [15:0] w(input logic [7:0] a);
        return {8'hC5, a};
    endfunction

    logic [7:0] pc_plus1;
    assign pc_plus1    = fetch_pc + 8'd1;
    assign imem_instr1 = w(fetch_pc);
    assign imem_instr2 = w(pc_plus1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        imem_valid   = 1'b1;
        consume      = 2'd0;
        redirect     = 1'b0;
        redirect_pc  = 8'h00;

        // Reset with memory valid
        step(); step();
        chk("rst_count",  32'(count),      32'd0);
        chk("rst_outcnt", 32'(out_count),  32'd0);
        chk("rst_i1",     32'(instr1_out), 32'd0);
        chk("rst_i2",     32'(instr2_out), 32'd0);
        chk("rst_pc",     32'(fetch_pc),   32'd0);
        chk("rst_req",    32'(fetch_req),  32'd1);

        // First push puts words 0 and 1 on the outputs
        rst = 1'b0;
        step();
        chk("p1_i1",     32'(instr1_out), 32'(w(8'h00)));
        chk("p1_i2",     32'(instr2_out), 32'(w(8'h01)));
        chk("p1_outcnt", 32'(out_count),  32'd2);
        chk("p1_count",  32'(count),      32'd2);
        chk("p1_pc",     32'(fetch_pc),   32'd2);

        // Fill to full
        step(); step(); step();
        chk("full_count", 32'(count),     32'd8);
        chk("full_req",   32'(fetch_req), 32'd0);
        chk("full_pc",    32'(fetch_pc),  32'd8);
        step();
        chk("full_hold_count", 32'(count),      32'd8);
        chk("full_hold_pc",    32'(fetch_pc),   32'd8);
        chk("full_hold_i1",    32'(instr1_out), 32'(w(8'h00)));

        // Odd alignment: stall memory so the queue only drains
        imem_valid = 1'b0;
        consume    = 2'd1;
        step();
        chk("odd_i1",    32'(instr1_out), 32'(w(8'h01)));
        chk("odd_i2",    32'(instr2_out), 32'(w(8'h02)));
        chk("odd_count", 32'(count),      32'd7);
        chk("odd_req",   32'(fetch_req),  32'd0);
        consume = 2'd2;
        step();
        chk("odd_a3", 32'(instr1_out), 32'(w(8'h03)));
        chk("odd_a4", 32'(instr2_out), 32'(w(8'h04)));
        chk("odd_req_stall", 32'(fetch_req), 32'd1);
        consume = 2'd3;
        step();
        chk("odd_a5", 32'(instr1_out), 32'(w(8'h05)));
        chk("odd_a6", 32'(instr2_out), 32'(w(8'h06)));
        chk("odd_c3_count", 32'(count), 32'd3);
        consume = 2'd2;
        step();
        chk("odd_a7",     32'(instr1_out), 32'(w(8'h07)));
        chk("odd_a7_i2",  32'(instr2_out), 32'd0);
        chk("odd_outcnt", 32'(out_count),  32'd1);
        // Over-consume with one entry left
        step();
        chk("over_count",  32'(count),      32'd0);
        chk("over_outcnt", 32'(out_count),  32'd0);
        chk("over_i1",     32'(instr1_out), 32'd0);
        chk("stall_pc",    32'(fetch_pc),   32'd8);

        // Steady-state dual issue through pointer wrap
        imem_valid = 1'b1;
        consume    = 2'd2;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("ss_i1",    32'(instr1_out), 32'(w(8'(8 + 2 * k))));
            chk("ss_i2",    32'(instr2_out), 32'(w(8'(9 + 2 * k))));
            chk("ss_count", 32'(count),      32'd2);
        end
        chk("ss_pc", 32'(fetch_pc), 32'h14);

        // Build to six entries, then redirect mid-stream
        consume = 2'd0;
        step(); step();
        chk("pre_rd_count", 32'(count), 32'd6);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        consume     = 2'd2;
        step();
        chk("rd_count",  32'(count),     32'd0);
        chk("rd_outcnt", 32'(out_count), 32'd0);
        chk("rd_pc",     32'(fetch_pc),  32'h40);
        redirect = 1'b0;
        consume  = 2'd0;
        step();
        chk("rd_i1",    32'(instr1_out), 32'(w(8'h40)));
        chk("rd_i2",    32'(instr2_out), 32'(w(8'h41)));
        chk("rd_count2", 32'(count),     32'd2);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        step();
        chk("wr_pc0", 32'(fetch_pc), 32'hFE);
        redirect = 1'b0;
        step();
        chk("wr_i1", 32'(instr1_out), 32'(w(8'hFE)));
        chk("wr_i2", 32'(instr2_out), 32'(w(8'hFF)));
        chk("wr_pc", 32'(fetch_pc),   32'h00);
        step();
        consume = 2'd2;
        step();
        chk("wr2_i1",    32'(instr1_out), 32'(w(8'h00)));
        chk("wr2_i2",    32'(instr2_out), 32'(w(8'h01)));
        chk("wr2_count", 32'(count),      32'd4);
        chk("wr2_pc",    32'(fetch_pc),   32'h04);

        // Reset overrides a simultaneous redirect
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h77;
        step();
        chk("rstpri_pc",    32'(fetch_pc), 32'h00);
        chk("rstpri_count", 32'(count),    32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
